// File: rtl/get_cost_pkg.sv
// Shared encodings, state enum and sizing helpers for the get_cost_stream engine.
package get_cost_pkg;

  localparam logic [1:0] MODE_I16    = 2'd0;
  localparam logic [1:0] MODE_I4     = 2'd1;
  localparam logic [1:0] MODE_CHROMA = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam int NBLK_I16    = 16;
  localparam int NBLK_I4     = 16;
  localparam int NBLK_CHROMA = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Width that holds MAX_BLOCKS beats of (BLOCK_SIZE+1) full-scale squares.
  function automatic int acc_width(input int bw, input int bs, input int mb);
    return 2 * bw + $clog2(mb * (bs + 1));
  endfunction

  function automatic int blocks_for_mode(input logic [1:0] m);
    int n;
    case (m)
      MODE_I16:    n = NBLK_I16;
      MODE_CHROMA: n = NBLK_CHROMA;
      default:     n = NBLK_I4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/get_cost_stream_sq_sum_tree.sv
// Registers the squares of N signed lanes (each lane individually gated) and
// presents their combinational sum.
module sq_sum_tree #(
  parameter int W     = 16,
  parameter int N     = 17,
  parameter int OUT_W = 2 * W - 1 + $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N-1:0]     en,
  input  logic [W*N-1:0]   data,
  output logic [OUT_W-1:0] sum
);

  localparam int SQ_W = 2 * W - 1;

  logic [SQ_W-1:0] sq_r [N];

  // Square of a signed value is non-negative and fits 2W-1 bits, even for the most negative input.
  function automatic logic [SQ_W-1:0] square(input logic [W-1:0] x);
    logic signed [2*W-1:0] xe;
    logic signed [2*W-1:0] p;
    xe = {{W{x[W-1]}}, x};
    p  = xe * xe;
    return p[SQ_W-1:0];
  endfunction

  // Stage 1: square register per lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) sq_r[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < N; k++)
        sq_r[k] <= en[k] ? square(data[W*k +: W]) : '0;
    end
  end

  // Adder tree over the registered squares.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++)
      sum = sum + {{(OUT_W-SQ_W){1'b0}}, sq_r[k]};
  end

endmodule

// File: rtl/get_cost_stream.sv
// Streaming sum-of-squares cost engine for one macroblock of quantised coefficients.
// Define GET_COST_SAT_EN to saturate sum on overflow instead of wrapping.
module get_cost_stream
  import get_cost_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int BLOCK_SIZE = 16,
  parameter int MAX_BLOCKS = 16,
  parameter int SUM_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] in_ac,
  input  logic [BIT_WIDTH-1:0]       in_dc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SUM_W-1:0]           sum,
  output logic                       ovf
);

  localparam int ACC_W  = acc_width(BIT_WIDTH, BLOCK_SIZE, MAX_BLOCKS);
  localparam int LANES  = BLOCK_SIZE + 1;
  localparam int TREE_W = 2 * BIT_WIDTH - 1 + $clog2(LANES);
  localparam int CNT_W  = $clog2(MAX_BLOCKS + 1);

  state_t             state_r, state_s;
  logic [1:0]         mode_r;
  logic [CNT_W-1:0]   nblk_r, beats_r;
  logic               drain_r, s1_valid_r;
  logic [ACC_W-1:0]   acc_r;
  logic [SUM_W-1:0]   sum_r, sum_s;
  logic               ovf_r, ovf_s;
  logic [TREE_W-1:0]  tree_sum_s;
  logic               start_fire_s, beat_fire_s, last_beat_s, dc_en_s;

  assign busy      = (state_r != ST_IDLE);
  assign in_ready  = (state_r == ST_ACC);
  assign out_valid = (state_r == ST_OUT);
  assign sum       = sum_r;
  assign ovf       = ovf_r;

  assign start_fire_s = (state_r == ST_IDLE) && start;
  assign beat_fire_s  = in_valid && in_ready;
  assign last_beat_s  = beat_fire_s && ((beats_r + CNT_W'(1)) == nblk_r);
  assign dc_en_s      = (mode_r != MODE_I4);

  sq_sum_tree #(
    .W     (BIT_WIDTH),
    .N     (LANES),
    .OUT_W (TREE_W)
  ) u_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (beat_fire_s),
    .en    ({dc_en_s, {BLOCK_SIZE{1'b1}}}),
    .data  ({in_dc, in_ac}),
    .sum   (tree_sum_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start)       state_s = ST_ACC;   else state_s = ST_IDLE;
      ST_ACC:   if (last_beat_s) state_s = ST_DRAIN; else state_s = ST_ACC;
      ST_DRAIN: if (drain_r)     state_s = ST_OUT;   else state_s = ST_DRAIN;
      ST_OUT:   if (out_ready)   state_s = ST_IDLE;  else state_s = ST_OUT;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Mode latch, beat counter, drain timer and stage-1 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= MODE_I16;
      nblk_r     <= '0;
      beats_r    <= '0;
      drain_r    <= 1'b0;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= beat_fire_s;
      drain_r    <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
      if (start_fire_s) begin
        mode_r  <= (mode == MODE_RSVD) ? MODE_I4 : mode;
        nblk_r  <= CNT_W'(blocks_for_mode(mode));
        beats_r <= '0;
      end else if (beat_fire_s) begin
        beats_r <= beats_r + CNT_W'(1);
      end
    end
  end

  // Stage 2: fold the tree result into the macroblock accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            acc_r <= '0;
    else if (start_fire_s) acc_r <= '0;
    else if (s1_valid_r)   acc_r <= acc_r + {{(ACC_W-TREE_W){1'b0}}, tree_sum_s};
  end

  // Result formatting from the final accumulator value.
  always_comb begin
    ovf_s = |acc_r[ACC_W-1:SUM_W];
`ifdef GET_COST_SAT_EN
    if (ovf_s) sum_s = {SUM_W{1'b1}};
    else       sum_s = acc_r[SUM_W-1:0];
`else
    sum_s = acc_r[SUM_W-1:0];
`endif
  end

  // Output register, loaded on the DRAIN->OUT transition and held while OUT waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      ovf_r <= 1'b0;
    end else if ((state_r == ST_DRAIN) && drain_r) begin
      sum_r <= sum_s;
      ovf_r <= ovf_s;
    end
  end

endmodule

// File: tb/tb_get_cost_stream.sv
// Directed self-checking bench for get_cost_stream (honours GET_COST_SAT_EN for the overflow case).
module tb_get_cost_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_ac;
  logic [15:0]  in_dc;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  sum;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  get_cost_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_ac(in_ac), .in_dc(in_dc),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full macroblock: start, nbeats beats (optional bubbles / start pokes), drain, held output.
  task automatic run_mb(input string tag, input logic [1:0] m, input logic [255:0] ac,
                        input logic [15:0] dc, input int nbeats, input bit bubbles,
                        input int hold, input logic [31:0] exp_sum, input logic exp_ovf);
    int guard;
    int lat;
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 2'd0;
    check($sformatf("%s_busy_start", tag), 64'(busy), 64'd1);
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        start    = 1'b1;
        repeat ($urandom_range(0, 2)) tick();
        start    = 1'b0;
      end
      in_valid = 1'b1;
      in_ac    = ac;
      in_dc    = dc;
      guard    = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      check($sformatf("%s_ready_b%0d", tag, b), 64'(in_ready), 64'd1);
      tick();
    end
    check($sformatf("%s_ready_low", tag), 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check($sformatf("%s_latency", tag), 64'(lat), 64'd3);
    check($sformatf("%s_sum", tag), 64'(sum), 64'(exp_sum));
    check($sformatf("%s_ovf", tag), 64'(ovf), 64'(exp_ovf));
    in_valid = 1'b0;
    if (hold > 0) begin
      start = bubbles;
      repeat (hold) tick();
      check($sformatf("%s_hold_valid", tag), 64'(out_valid), 64'd1);
      check($sformatf("%s_hold_sum", tag), 64'(sum), 64'(exp_sum));
      check($sformatf("%s_hold_busy", tag), 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check($sformatf("%s_valid_drop", tag), 64'(out_valid), 64'd0);
    tick();
    check($sformatf("%s_busy_drop", tag), 64'(busy), 64'd0);
  endtask

  logic [255:0] ac_v;
  logic [31:0]  big_sum;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; in_valid = 1'b0;
    in_ac = '0; in_dc = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    run_mb("i16", 2'd0, {16{16'd1}}, 16'd2, 16, 1'b0, 0, 32'd320, 1'b0);
    run_mb("i4", 2'd1, {16{16'd1}}, 16'd2, 16, 1'b0, 0, 32'd256, 1'b0);
    run_mb("chroma", 2'd2, {16{16'd1}}, 16'd2, 8, 1'b0, 0, 32'd160, 1'b0);

`ifdef GET_COST_SAT_EN
    big_sum = 32'hFFFF_FFFF;
`else
    big_sum = 32'd0;
`endif
    run_mb("fullscale", 2'd0, {16{16'h8000}}, 16'h8000, 16, 1'b0, 0, big_sum, 1'b1);

    for (int k = 0; k < 16; k++) ac_v[16*k +: 16] = 16'(k - 8);
    run_mb("bubble_rsvd", 2'd3, ac_v, 16'd100, 16, 1'b1, 10, 32'd5504, 1'b0);

    for (int k = 0; k < 16; k++) ac_v[16*k +: 16] = (k % 2 == 0) ? 16'sd3 : -16'sd3;
    run_mb("signed", 2'd2, ac_v, -16'sd5, 8, 1'b0, 0, 32'd1352, 1'b0);

    start = 1'b1;
    mode  = 2'd0;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_ac    = {16{16'd7}};
    in_dc    = 16'd7;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_mb("after_rst", 2'd0, {16{16'd1}}, 16'd2, 16, 1'b0, 0, 32'd320, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
